// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Sequences instruction fetch from a 16-bit, byte-addressed instruction memory
//   with a combinational read. It owns the program counter, registers each
//   fetched word and presents it to decode over a valid/ready handshake. It
//   handles branch redirects, backpressure stalls, halt on a terminator word and
//   halt on running past the end of the program.
//
// Ports
//   clk, rst         : clock (rising edge), asynchronous active-high reset
//   start            : one-cycle pulse, (re)starts fetch from RESET_PC
//   redirect_valid   : branch/jump taken this cycle
//   redirect_pc      : branch target byte address (bit 0 is ignored)
//   mem_addr         : byte address to instruction memory (equals pc)
//   mem_rdata        : instruction word returned for mem_addr, same cycle
//   instr_valid      : instr_out/instr_pc hold a valid instruction
//   instr_out        : registered instruction word
//   instr_pc         : byte address of instr_out
//   instr_ready      : decode accepts the presented instruction this cycle
//   halted           : high while in HALT
//   pc               : current fetch PC
//   fetch_count      : accepted instructions, saturating at 16'hFFFF
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] PROG_END  = 16'h0032,
  parameter logic [15:0] HALT_WORD = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  output logic        instr_valid,
  output logic [15:0] instr_out,
  output logic [15:0] instr_pc,
  input  logic        instr_ready,
  output logic        halted,
  output logic [15:0] pc,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [15:0] out_q, out_d;
  logic [15:0] ipc_q, ipc_d;
  logic [15:0] count_q, count_d;

  logic        xfer;
  logic        slot_free;

  // Saturating increment for the accepted-instruction counter.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign xfer      = valid_q & instr_ready;
  assign slot_free = ~valid_q | instr_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    out_d   = out_q;
    ipc_d   = ipc_q;
    // The handshake completes even when a redirect or start flushes the slot.
    count_d = xfer ? sat_inc(count_q) : count_q;

    if (start) begin
      state_d = S_FETCH;
      pc_d    = RESET_PC;
      valid_d = 1'b0;
    end else if (redirect_valid) begin
      pc_d = redirect_pc & 16'hFFFE;
      // In IDLE a redirect only preloads the PC; fetch still waits for start.
      if (state_q != S_IDLE) begin
        state_d = S_FETCH;
        valid_d = 1'b0;
      end
    end else if (state_q == S_FETCH && slot_free) begin
      if (pc_q >= PROG_END || mem_rdata == HALT_WORD) begin
        state_d = S_HALT;
        valid_d = 1'b0;
      end else begin
        out_d   = mem_rdata;
        ipc_d   = pc_q;
        valid_d = 1'b1;
        pc_d    = pc_q + 16'd2;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      out_q   <= 16'h0000;
      ipc_q   <= 16'h0000;
      count_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      out_q   <= out_d;
      ipc_q   <= ipc_d;
      count_q <= count_d;
    end
  end

  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign instr_valid = valid_q;
  assign instr_out   = out_q;
  assign instr_pc    = ipc_q;
  assign halted      = (state_q == S_HALT);
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        instr_valid;
  logic [15:0] instr_out;
  logic [15:0] instr_pc;
  logic        instr_ready;
  logic        halted;
  logic [15:0] pc;
  logic [15:0] fetch_count;

  logic [15:0] memw [0:255];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign mem_rdata = memw[mem_addr[8:1]];

  fetch_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .instr_valid    (instr_valid),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .halted         (halted),
    .pc             (pc),
    .fetch_count    (fetch_count)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        st;
    logic        rv;
    logic [15:0] rpc;
    logic        rdy;
    logic        e_valid;
    logic [15:0] e_out;
    logic [15:0] e_ipc;
    logic [15:0] e_pc;
    logic        e_halt;
    logic [15:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic rv, input logic [15:0] rpc,
                              input logic rdy, input logic v, input logic [15:0] o,
                              input logic [15:0] ip, input logic [15:0] p,
                              input logic h, input logic [15:0] c);
    vec_t r;
    r.st = st; r.rv = rv; r.rpc = rpc; r.rdy = rdy;
    r.e_valid = v; r.e_out = o; r.e_ipc = ip; r.e_pc = p; r.e_halt = h; r.e_cnt = c;
    return r;
  endfunction

  // Behavioural reference: the spec's per-cycle rules applied to plain variables.
  localparam int M_IDLE = 0, M_FETCH = 1, M_HALT = 2;
  int          m_state;
  logic [15:0] m_pc, m_out, m_ipc, m_cnt;
  logic        m_valid;

  task automatic model_reset();
    m_state = M_IDLE; m_pc = 16'h0000; m_valid = 1'b0;
    m_out = 16'h0000; m_ipc = 16'h0000; m_cnt = 16'h0000;
  endtask

  task automatic model_step(input logic st, input logic rv, input logic [15:0] rpc, input logic rdy);
    logic [15:0] word;
    word = memw[m_pc[8:1]];
    if (m_valid && rdy && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    if (st) begin
      m_state = M_FETCH; m_pc = 16'h0000; m_valid = 1'b0;
    end else if (rv) begin
      m_pc = {rpc[15:1], 1'b0};
      if (m_state != M_IDLE) begin m_state = M_FETCH; m_valid = 1'b0; end
    end else if (m_state == M_FETCH && (!m_valid || rdy)) begin
      if (m_pc >= 16'h0032 || word == 16'h0000) begin
        m_state = M_HALT; m_valid = 1'b0;
      end else begin
        m_out = word; m_ipc = m_pc; m_valid = 1'b1; m_pc = m_pc + 16'd2;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0; instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  vec_t vt [17];

  initial begin
    logic [15:0] last_ipc;
    bit          done;
    logic        r_st, r_rv, r_rdy;
    logic [15:0] r_rpc;

    // Directed table: program 1111, 2222, 0000 plus 8888 at 0x0010.
    vt[0]  = mk(0, 1, 16'h0007, 1, 0, 16'h0000, 16'h0000, 16'h0006, 0, 16'd0);
    vt[1]  = mk(1, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'd0);
    vt[2]  = mk(0, 0, 16'h0000, 1, 1, 16'h1111, 16'h0000, 16'h0002, 0, 16'd0);
    vt[3]  = mk(0, 0, 16'h0000, 1, 1, 16'h2222, 16'h0002, 16'h0004, 0, 16'd1);
    vt[4]  = mk(0, 0, 16'h0000, 1, 0, 16'h2222, 16'h0002, 16'h0004, 1, 16'd2);
    vt[5]  = mk(1, 0, 16'h0000, 1, 0, 16'h2222, 16'h0002, 16'h0000, 0, 16'd2);
    vt[6]  = mk(0, 0, 16'h0000, 0, 1, 16'h1111, 16'h0000, 16'h0002, 0, 16'd2);
    vt[7]  = mk(0, 0, 16'h0000, 0, 1, 16'h1111, 16'h0000, 16'h0002, 0, 16'd2);
    vt[8]  = mk(0, 0, 16'h0000, 0, 1, 16'h1111, 16'h0000, 16'h0002, 0, 16'd2);
    vt[9]  = mk(0, 0, 16'h0000, 1, 1, 16'h2222, 16'h0002, 16'h0004, 0, 16'd3);
    vt[10] = mk(0, 0, 16'h0000, 1, 0, 16'h2222, 16'h0002, 16'h0004, 1, 16'd4);
    vt[11] = mk(0, 1, 16'h0001, 0, 0, 16'h2222, 16'h0002, 16'h0000, 0, 16'd4);
    vt[12] = mk(0, 0, 16'h0000, 0, 1, 16'h1111, 16'h0000, 16'h0002, 0, 16'd4);
    vt[13] = mk(0, 1, 16'h0011, 0, 0, 16'h1111, 16'h0000, 16'h0010, 0, 16'd4);
    vt[14] = mk(0, 0, 16'h0000, 0, 1, 16'h8888, 16'h0010, 16'h0012, 0, 16'd4);
    vt[15] = mk(0, 1, 16'h0000, 1, 0, 16'h8888, 16'h0010, 16'h0000, 0, 16'd5);
    vt[16] = mk(0, 0, 16'h0000, 1, 1, 16'h1111, 16'h0000, 16'h0002, 0, 16'd5);

    for (int i = 0; i < 256; i++) memw[i] = 16'h0000;
    memw[0] = 16'h1111; memw[1] = 16'h2222; memw[8] = 16'h8888;

    do_reset();
    chk("reset valid", {15'h0, instr_valid}, 16'h0);
    chk("reset pc", pc, 16'h0000);
    chk("reset halted", {15'h0, halted}, 16'h0);
    chk("reset count", fetch_count, 16'h0000);
    chk("reset out", instr_out, 16'h0000);

    for (int i = 0; i < 17; i++) begin
      start = vt[i].st; redirect_valid = vt[i].rv; redirect_pc = vt[i].rpc; instr_ready = vt[i].rdy;
      @(posedge clk); #1;
      chk($sformatf("vec%0d valid", i), {15'h0, instr_valid}, {15'h0, vt[i].e_valid});
      chk($sformatf("vec%0d out", i), instr_out, vt[i].e_out);
      chk($sformatf("vec%0d ipc", i), instr_pc, vt[i].e_ipc);
      chk($sformatf("vec%0d pc", i), pc, vt[i].e_pc);
      chk($sformatf("vec%0d mem_addr", i), mem_addr, vt[i].e_pc);
      chk($sformatf("vec%0d halted", i), {15'h0, halted}, {15'h0, vt[i].e_halt});
      chk($sformatf("vec%0d count", i), fetch_count, vt[i].e_cnt);
    end

    // Straight-line program running into PROG_END.
    for (int i = 0; i < 256; i++) memw[i] = 16'hA000 | 16'(i);
    do_reset();
    start = 1'b1; instr_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    last_ipc = 16'hFFFF; done = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(posedge clk); #1;
      if (instr_valid) last_ipc = instr_pc;
      if (halted) done = 1;
    end
    n_chk++;
    if (!done) begin n_fail++; $display("FAIL straight halt timeout: halted=%0b after 60 cycles", halted); end
    chk("straight last ipc", last_ipc, 16'h0030);
    chk("straight pc", pc, 16'h0032);
    chk("straight count", fetch_count, 16'd25);

    // Asynchronous reset while an instruction is held.
    instr_ready = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    chk("pre-rst valid", {15'h0, instr_valid}, 16'h1);
    #2 rst = 1'b1;
    #1;
    chk("async rst valid", {15'h0, instr_valid}, 16'h0);
    chk("async rst pc", pc, 16'h0000);
    chk("async rst halted", {15'h0, halted}, 16'h0);
    chk("async rst count", fetch_count, 16'h0000);
    #1 rst = 1'b0; instr_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("idle no fetch valid", {15'h0, instr_valid}, 16'h0);
      chk("idle no fetch pc", pc, 16'h0000);
    end

    // Randomized run against the reference model.
    for (int i = 0; i < 256; i++)
      memw[i] = ($urandom_range(0, 7) == 0) ? 16'h0000 : (16'($urandom) | 16'h0001);
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      r_st  = ($urandom_range(0, 15) == 0);
      r_rv  = ($urandom_range(0, 9) == 0);
      r_rpc = 16'($urandom_range(0, 63));
      r_rdy = ($urandom_range(0, 1) == 1);
      start = r_st; redirect_valid = r_rv; redirect_pc = r_rpc; instr_ready = r_rdy;
      model_step(r_st, r_rv, r_rpc, r_rdy);
      @(posedge clk); #1;
      chk("rand valid", {15'h0, instr_valid}, {15'h0, m_valid});
      if (m_valid) begin
        chk("rand out", instr_out, m_out);
        chk("rand ipc", instr_pc, m_ipc);
      end
      chk("rand pc", pc, m_pc);
      chk("rand halted", {15'h0, halted}, {15'h0, (m_state == M_HALT)});
      chk("rand count", fetch_count, m_cnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences instruction fetch from the 16-bit, byte-addressed instruction memory, which returns little-endian 16-bit words with a combinational read.
- Owns the program counter and drives the memory address each cycle.
- Registers the returned word and presents it to decode over a valid/ready handshake.
- Handles branch redirects, backpressure stalls, halt-on-terminator and halt-on-end-of-program.

Parameters:
RESET_PC, 16'h0000, PC value loaded at reset and on start.
PROG_END, 16'h0032, first byte address outside the program; a fetch with pc >= PROG_END halts.
HALT_WORD, 16'h0000, instruction encoding that terminates execution.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  one-cycle pulse; begins or restarts fetch from RESET_PC.
redirect_valid  input  1  branch/jump taken this cycle.
redirect_pc  input  16  branch target byte address.
mem_addr  output  16  byte address to instruction memory; combinationally equal to pc.
mem_rdata  input  16  instruction word from memory, valid in the same cycle as mem_addr.
instr_valid  output  1  instr_out/instr_pc hold a valid instruction.
instr_out  output  16  registered instruction word.
instr_pc  output  16  byte address of instr_out.
instr_ready  input  1  decode accepts the instruction this cycle.
halted  output  1  high while in HALT.
pc  output  16  current fetch PC.
fetch_count  output  16  number of instructions accepted (instr_valid & instr_ready); saturates at 16'hFFFF.

Behaviour:
- Reset (async, any state):
  - pc=RESET_PC, state=IDLE.
  - instr_valid=0, instr_out=0, instr_pc=0.
  - halted=0, fetch_count=0.
  - Reset mid-stall discards the held instruction.
- States: IDLE, FETCH, HALT.
- IDLE:
  - No capture.
  - start -> pc=RESET_PC, FETCH.
  - redirect_valid (without start) -> pc=redirect_pc with bit0 cleared; stay IDLE.
- FETCH: the slot is free when instr_valid==0 or instr_ready==1. Each cycle with a free slot:
  - If pc >= PROG_END: no capture, instr_valid=0, go HALT.
  - Else if mem_rdata==HALT_WORD: no capture, instr_valid=0, pc unchanged, go HALT.
  - Else: instr_out=mem_rdata, instr_pc=pc, instr_valid=1, pc=pc+2 (16-bit modulo).
- Stall: instr_valid=1 and instr_ready=0 -> instr_out, instr_pc, instr_valid and pc all hold.
- Latency: the first instr_valid is asserted one cycle after entering FETCH. Sustained throughput is one instruction per cycle while instr_ready=1.
- Redirect (FETCH or HALT):
  - Overrides capture in the same cycle.
  - instr_valid=0 (the presented instruction is flushed, not counted), pc=redirect_pc & 16'hFFFE, state FETCH.
- HALT:
  - halted=1, instr_valid=0.
  - start -> pc=RESET_PC, FETCH.
  - redirect -> as above.
- Priority: rst > start > redirect_valid > normal fetch. Start in FETCH also flushes and reloads RESET_PC.
- fetch_count:
  - Increments on every cycle with instr_valid & instr_ready, including a cycle where a redirect also occurs; the transfer completes first.
  - Holds at 16'hFFFF; cleared only by rst.
- halted deasserts on the cycle leaving HALT.

Test Plan:
- Memory words 0x1111, 0x2222, 0x0000 at 0x00/0x02/0x04; rst, start, instr_ready=1 -> instr_out 0x1111 (instr_pc 0x0000) then 0x2222 (0x0002); halted=1 next cycle; fetch_count=2; pc=0x0004.
- Straight-line nonzero program, instr_ready=1 -> last instr_pc=0x0030; halted=1 when pc=0x0032; fetch_count=25.
- instr_ready=0 for 3 cycles while instr_out=0x1111 -> instr_out, instr_pc=0x0000, pc=0x0002 all stable; resumes with 0x2222 after ready rises.
- redirect_valid with redirect_pc=0x0011 while instr_valid=1, instr_ready=0 -> next cycle instr_valid=0, pc=0x0010; following cycle instr_pc=0x0010; fetch_count unchanged.
- Assert rst mid-FETCH with instr_valid=1 -> immediately instr_valid=0, pc=RESET_PC, halted=0, fetch_count=0; no fetch until start.
- From HALT, pulse start -> pc=0x0000, halted=0 next cycle; instructions replay from 0x0000; fetch_count continues accumulating.
